// File: rtl/dmem_bist_master_if.sv
// Data-memory port bundle shared by the PMIPS core and the BIST initiator.
// The initiator drives address, write data and strobes; the memory returns read data.
interface dmem_bist_master_if;
  logic [15:0] dmemaddr;
  logic [15:0] dmemwdata;
  logic        dmemwrite;
  logic        dmemread;
  logic [15:0] dmemrdata;

  modport master (
    output dmemaddr,
    output dmemwdata,
    output dmemwrite,
    output dmemread,
    input  dmemrdata
  );

  modport slave (
    input  dmemaddr,
    input  dmemwdata,
    input  dmemwrite,
    input  dmemread,
    output dmemrdata
  );
endinterface

// File: rtl/dmem_bist_master.sv
// Two-pass pattern BIST initiator for the PMIPS data-memory port: write/compare P(a),
// then write/compare ~P(a) over [START_ADDR, END_ADDR], reporting pass, error count and first bad address.
module dmem_bist_master #(
  parameter logic [15:0] START_ADDR = 16'h0000,
  parameter logic [15:0] END_ADDR   = 16'h007E,
  parameter logic [15:0] ADDR_STEP  = 16'd2,
  parameter logic [15:0] SEED       = 16'hA5C3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  dmem_bist_master_if.master dmem,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [15:0]        err_count,
  output logic [15:0]        first_err_addr
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR0  = 3'd1,
    S_RD0  = 3'd2,
    S_WR1  = 3'd3,
    S_RD1  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] err_count_q, err_count_d;
  logic [15:0] first_err_q, first_err_d;
  logic        pass_q, pass_d;

  logic [15:0] pattern;
  logic [15:0] expected;
  logic        inverted;
  logic        is_write;
  logic        is_read;
  logic        last_word;
  logic        mismatch;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      addr_q      <= 16'h0000;
      err_count_q <= 16'h0000;
      first_err_q <= 16'h0000;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      err_count_q <= err_count_d;
      first_err_q <= first_err_d;
      pass_q      <= pass_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    err_count_d = err_count_q;
    first_err_d = first_err_q;
    pass_d      = pass_q;

    inverted  = (state_q == S_WR1) || (state_q == S_RD1);
    is_write  = (state_q == S_WR0) || (state_q == S_WR1);
    is_read   = (state_q == S_RD0) || (state_q == S_RD1);
    pattern   = addr_q ^ SEED;
    expected  = inverted ? ~pattern : pattern;
    last_word = (addr_q == END_ADDR);
    mismatch  = is_read && (dmem.dmemrdata != expected);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_WR0;
          addr_d      = START_ADDR;
          err_count_d = 16'h0000;
          first_err_d = 16'h0000;
          pass_d      = 1'b0;
        end
      end

      S_WR0, S_WR1: begin
        if (abort) begin
          state_d = S_DONE;
          pass_d  = 1'b0;
        end else if (last_word) begin
          state_d = (state_q == S_WR0) ? S_RD0 : S_RD1;
          addr_d  = START_ADDR;
        end else begin
          addr_d = addr_q + ADDR_STEP;
        end
      end

      S_RD0, S_RD1: begin
        // An aborted read is not scored, so the error results stay as they were.
        if (abort) begin
          state_d = S_DONE;
          pass_d  = 1'b0;
        end else begin
          if (mismatch) begin
            if (err_count_q != 16'hFFFF) begin
              err_count_d = err_count_q + 16'd1;
            end
            if (err_count_q == 16'h0000) begin
              first_err_d = addr_q;
            end
          end
          if (last_word) begin
            addr_d = START_ADDR;
            if (state_q == S_RD0) begin
              state_d = S_WR1;
            end else begin
              state_d = S_DONE;
              pass_d  = (err_count_d == 16'h0000);
            end
          end else begin
            addr_d = addr_q + ADDR_STEP;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Bus outputs are decoded from registered state so reset clears them without a clock.
  assign dmem.dmemaddr  = (is_write || is_read) ? addr_q : 16'h0000;
  assign dmem.dmemwdata = is_write ? expected : 16'h0000;
  assign dmem.dmemwrite = is_write;
  assign dmem.dmemread  = is_read;

  assign busy           = is_write || is_read;
  assign done           = (state_q == S_DONE);
  assign pass           = pass_q;
  assign err_count      = err_count_q;
  assign first_err_addr = first_err_q;

endmodule

// File: tb/tb_dmem_bist_master.sv
// Bench for dmem_bist_master: fault-injecting memory model, table-driven directed runs,
// randomized fault runs against a pass-by-pass reference model, and abort/reset/single-word sequences.
module tb_dmem_bist_master;
  localparam logic [15:0] SEED = 16'hA5C3;
  localparam int N = 64;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset, start, abort, start_b, abort_b;
  logic busy, done, pass;
  logic [15:0] err_count, first_err_addr;
  logic busy_b, done_b, pass_b;
  logic [15:0] err_count_b, first_err_addr_b;

  dmem_bist_master_if dif ();
  dmem_bist_master_if dif_b ();

  dmem_bist_master dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort), .dmem(dif),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count), .first_err_addr(first_err_addr)
  );

  dmem_bist_master #(.START_ADDR(16'h0040), .END_ADDR(16'h0040)) dut_b (
    .clock(clock), .reset(reset), .start(start_b), .abort(abort_b), .dmem(dif_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_count_b), .first_err_addr(first_err_addr_b)
  );

  // Memory with per-word read faults: read = (stored & and_m) | or_m
  logic [15:0] mem   [0:32767];
  logic [15:0] and_m [0:32767];
  logic [15:0] or_m  [0:32767];
  logic [15:0] mem_b;

  always @(posedge clock) begin
    if (dif.dmemwrite) mem[dif.dmemaddr[15:1]] <= dif.dmemwdata;
    if (dif_b.dmemwrite) mem_b <= dif_b.dmemwdata;
  end
  assign dif.dmemrdata = (mem[dif.dmemaddr[15:1]] & and_m[dif.dmemaddr[15:1]]) | or_m[dif.dmemaddr[15:1]];
  assign dif_b.dmemrdata = mem_b;

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
  } acc_t;

  acc_t log_q[$];
  acc_t log_b[$];
  int   proto_viol = 0;

  always @(negedge clock) begin
    if (dif.dmemwrite || dif.dmemread) log_q.push_back(acc_t'{dif.dmemwrite, dif.dmemaddr, dif.dmemwdata});
    if (dif_b.dmemwrite || dif_b.dmemread) log_b.push_back(acc_t'{dif_b.dmemwrite, dif_b.dmemaddr, dif_b.dmemwdata});
    if (dif.dmemwrite && dif.dmemread) proto_viol++;
    if (!dif.dmemwrite && dif.dmemwdata != 16'h0000) proto_viol++;
    if (dif_b.dmemwrite && dif_b.dmemread) proto_viol++;
    if (!dif_b.dmemwrite && dif_b.dmemwdata != 16'h0000) proto_viol++;
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_faults();
    for (int i = 0; i < 32768; i++) begin
      and_m[i] = 16'hFFFF;
      or_m[i]  = 16'h0000;
    end
  endtask

  // Reference: pass p writes P or ~P to every word, then reads it back through the fault masks.
  function automatic void model(output logic [15:0] e_err, output logic [15:0] e_first);
    e_err = 16'h0000;
    e_first = 16'h0000;
    for (int p = 0; p < 2; p++) begin
      for (int w = 0; w < N; w++) begin
        logic [15:0] a, wv, rv;
        a  = 16'(2 * w);
        wv = (p == 0) ? (a ^ SEED) : ~(a ^ SEED);
        rv = (wv & and_m[w]) | or_m[w];
        if (rv != wv) begin
          if (e_err == 16'h0000) e_first = a;
          if (e_err != 16'hFFFF) e_err = e_err + 16'd1;
        end
      end
    end
  endfunction

  // Expected access stream: N writes of P, N reads, N writes of ~P, N reads, ascending addresses.
  function automatic int log_errors();
    int errs = 0;
    for (int i = 0; i < log_q.size(); i++) begin
      int p, w;
      acc_t e;
      p = i / N;
      w = i % N;
      e.wr   = (p % 2 == 0);
      e.addr = 16'(2 * w);
      e.data = !e.wr ? 16'h0000 : (p == 0) ? (e.addr ^ SEED) : ~(e.addr ^ SEED);
      if (log_q[i] != e) errs++;
    end
    return errs;
  endfunction

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  // Counts edges after the accepted-start edge until done is seen; optionally re-pulses start mid-test.
  task automatic wait_done(input int limit, input int midstart, output int cyc);
    cyc = 0;
    while (cyc < limit) begin
      @(negedge clock);
      if (done) break;
      start = (cyc == midstart);
      @(posedge clock);
      cyc++;
      #1 start = 1'b0;
    end
  endtask

  task automatic run_full(input string name, input logic [15:0] e_err, input logic [15:0] e_first, input int midstart);
    int cyc;
    log_q.delete();
    pulse_start();
    wait_done(1000, midstart, cyc);
    check({name, " done_cycle"}, cyc + 1, 4 * N + 1);
    check({name, " err_count"}, err_count, e_err);
    check({name, " first_err_addr"}, first_err_addr, e_first);
    check({name, " pass"}, pass, (e_err == 16'h0000));
    check({name, " busy"}, busy, 0);
    check({name, " access_count"}, log_q.size(), 4 * N);
    check({name, " access_stream"}, log_errors(), 0);
    $display("run %s: done_cycle=%0d err_count=%h first_err_addr=%h pass=%0d", name, cyc + 1, err_count, first_err_addr, pass);
  endtask

  typedef struct packed {
    logic [1:0]  mode;
    logic [15:0] e_err;
    logic [15:0] e_first;
  } vec_t;

  initial begin
    vec_t  vecs[3];
    string vnames[3];
    logic [15:0] e_err, e_first;
    int cyc, strobe_seen;

    vecs[0] = '{2'd0, 16'd0, 16'h0000};  vnames[0] = "clean";
    vecs[1] = '{2'd1, 16'd1, 16'h0010};  vnames[1] = "stuck_bit3";
    vecs[2] = '{2'd2, 16'd4, 16'h0020};  vnames[2] = "dead_words";

    for (int i = 0; i < 32768; i++) mem[i] = 16'h0000;
    mem_b = 16'h0000;
    clear_faults();
    start = 0; abort = 0; start_b = 0; abort_b = 0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    check("reset status", {busy, done, pass, err_count, first_err_addr}, 0);
    check("reset bus", {dif.dmemaddr, dif.dmemwdata, dif.dmemwrite, dif.dmemread}, 0);
    repeat (2) @(posedge clock);
    @(negedge clock) reset = 1'b1;

    // Directed table; the clean run also re-pulses start mid-test, which must be ignored
    for (int v = 0; v < 3; v++) begin
      clear_faults();
      if (vecs[v].mode == 2'd1) or_m[8] = 16'h0008;
      if (vecs[v].mode == 2'd2) begin
        and_m[16] = 16'h0000;
        and_m[24] = 16'h0000;
      end
      run_full(vnames[v], vecs[v].e_err, vecs[v].e_first, (v == 0) ? 30 : -1);
      if (v == 0 && log_q.size() >= 2) begin
        check("clean first_write", log_q[0], acc_t'{1'b1, 16'h0000, 16'hA5C3});
        check("clean second_write", log_q[1], acc_t'{1'b1, 16'h0002, 16'hA5C1});
      end
    end

    // Abort during RD0 at cycle 80 with one error already logged, then restart at cycle 90
    clear_faults();
    or_m[8] = 16'h0008;
    pulse_start();
    repeat (79) @(posedge clock);
    @(negedge clock) abort = 1'b1;
    @(posedge clock);
    #1 abort = 1'b0;
    @(negedge clock);
    check("abort busy", busy, 0);
    check("abort done", done, 1);
    check("abort pass", pass, 0);
    check("abort err_count", err_count, 16'd1);
    check("abort first_err_addr", first_err_addr, 16'h0010);
    strobe_seen = int'(dif.dmemwrite | dif.dmemread);
    repeat (8) begin
      @(negedge clock);
      strobe_seen += int'(dif.dmemwrite | dif.dmemread);
    end
    check("abort strobes_idle", strobe_seen, 0);
    clear_faults();
    log_q.delete();
    @(negedge clock) start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    wait_done(1000, -1, cyc);
    check("restart done_cycle", 90 + cyc + 1, 347);
    check("restart pass", pass, 1);
    check("restart err_count", err_count, 0);
    $display("run abort_restart: done_cycle=%0d pass=%0d", 90 + cyc + 1, pass);

    // start together with abort while busy: abort wins
    pulse_start();
    repeat (9) @(posedge clock);
    @(negedge clock) begin abort = 1'b1; start = 1'b1; end
    @(posedge clock);
    #1 begin abort = 1'b0; start = 1'b0; end
    @(negedge clock);
    check("abort_start busy", busy, 0);
    check("abort_start done", done, 1);
    $display("run abort_with_start: busy=%0d done=%0d", busy, done);

    // Asynchronous reset in the middle of WR1
    pulse_start();
    repeat (140) @(posedge clock);
    #2;
    check("pre_reset busy", busy, 1);
    reset = 1'b0;
    #1;
    check("async_reset status", {busy, done, pass, err_count, first_err_addr}, 0);
    check("async_reset bus", {dif.dmemaddr, dif.dmemwdata, dif.dmemwrite, dif.dmemread}, 0);
    @(posedge clock);
    @(negedge clock) reset = 1'b1;
    @(negedge clock);
    check("post_reset idle", {busy, done}, 0);
    $display("run async_reset: busy=%0d done=%0d", busy, done);

    // Randomized fault sets checked against the reference model
    for (int r = 0; r < 6; r++) begin
      int k;
      clear_faults();
      k = $urandom_range(0, 4);
      for (int j = 0; j < k; j++) begin
        int idx;
        logic [15:0] bitv;
        idx  = $urandom_range(0, N - 1);
        bitv = 16'd1 << $urandom_range(0, 15);
        if ($urandom_range(0, 1) == 1) or_m[idx] = or_m[idx] | bitv;
        else and_m[idx] = and_m[idx] & ~bitv;
      end
      model(e_err, e_first);
      run_full($sformatf("random%0d", r), e_err, e_first, -1);
    end

    // Single-word instance
    log_b.delete();
    @(negedge clock) start_b = 1'b1;
    @(posedge clock);
    #1 start_b = 1'b0;
    cyc = 0;
    while (cyc < 50) begin
      @(negedge clock);
      if (done_b) break;
      @(posedge clock);
      cyc++;
    end
    check("single done_cycle", cyc + 1, 5);
    check("single pass", pass_b, 1);
    check("single err_count", err_count_b, 0);
    check("single access_count", log_b.size(), 4);
    if (log_b.size() == 4) begin
      check("single access0", log_b[0], acc_t'{1'b1, 16'h0040, 16'hA583});
      check("single access1", log_b[1], acc_t'{1'b0, 16'h0040, 16'h0000});
      check("single access2", log_b[2], acc_t'{1'b1, 16'h0040, 16'h5A7C});
      check("single access3", log_b[3], acc_t'{1'b0, 16'h0040, 16'h0000});
    end
    $display("run single_word: done_cycle=%0d accesses=%0d pass=%0d", cyc + 1, log_b.size(), pass_b);

    check("bus protocol", proto_viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
